// File: rtl/l1_icache.sv
// l1_icache: direct-mapped instruction cache with one-word lines, single-word refill and a line-by-line flush walk.
// Build macro L1_ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module l1_icache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LINES  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data
`ifdef L1_ICACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              flush_pend_q, flush_pend_d;
  logic [IDX_W-1:0]  fcnt_q, fcnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [DATA_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];

  logic [IDX_W-1:0]  req_idx_s, fill_idx_s;
  logic [TAG_W-1:0]  req_tag_s, fill_tag_s;
  logic              hit_s, fill_we_s;

  assign req_idx_s  = req_addr[IDX_W-1:0];
  assign req_tag_s  = req_addr[ADDR_W-1:IDX_W];
  assign fill_idx_s = mem_addr_q[IDX_W-1:0];
  assign fill_tag_s = mem_addr_q[ADDR_W-1:IDX_W];
  assign hit_s      = valid_q[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s);
  assign req_ready  = (state_q == ST_IDLE) && !flush;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    fcnt_d       = fcnt_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
          fcnt_d  = '0;
        end else if (req_valid) begin
          if (hit_s) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data_mem[req_idx_s];
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = req_addr;
            state_d    = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        flush_pend_d = flush_pend_q | flush;
        if (mem_ack) begin
          fill_we_s            = 1'b1;
          valid_d[fill_idx_s]  = 1'b1;
          rsp_valid_d          = 1'b1;
          rsp_data_d           = mem_data;
          mem_req_d            = 1'b0;
          // A flush seen at any point of the refill starts its walk right after the response.
          if (flush_pend_q || flush) begin
            state_d      = ST_FLUSH;
            fcnt_d       = '0;
            flush_pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FLUSH: begin
        valid_d[fcnt_q] = 1'b0;
        if (fcnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; everything freezes while clk_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      fcnt_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else if (clk_en) begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      fcnt_q       <= fcnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Data and tag storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (clk_en && fill_we_s) begin
      data_mem[fill_idx_s] <= mem_data;
      tag_mem[fill_idx_s]  <= fill_tag_s;
    end
  end

`ifdef L1_ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        acc_hit_s, acc_miss_s;

  assign acc_hit_s  = req_ready && req_valid && hit_s;
  assign acc_miss_s = req_ready && req_valid && !hit_s;

  // Saturating hit/miss counters; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else if (clk_en) begin
      if (acc_hit_s && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (acc_miss_s && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_icache.sv
// Randomized self-checking bench for l1_icache against a transaction-level cache model.
module tb_l1_icache;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NL = 64;

  logic          clk = 1'b0;
  logic          rst_n, clk_en, req_valid, flush, mem_ack;
  logic [AW-1:0] req_addr;
  logic          req_ready, rsp_valid, mem_req;
  logic [DW-1:0] rsp_data, mem_data;
  logic [AW-1:0] mem_addr;
`ifdef L1_ICACHE_STATS_EN
  logic [15:0]   hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: line contents plus expected statistics.
  bit            mv [NL];
  logic [9:0]    mt [NL];
  logic [DW-1:0] md [NL];
  int            mh = 0;
  int            mm = 0;

  l1_icache #(.ADDR_W(AW), .DATA_W(DW), .LINES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
`ifdef L1_ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
  endtask

  task automatic wait_flush_done(input int start_n);
    int n;
    n = start_n;
    while (n < 300) begin
      #1;
      if (req_ready) break;
      @(posedge clk); #1;
      n++;
    end
    chk("flush_len", n, 64);
    model_clear();
  endtask

  task automatic fetch(input logic [AW-1:0] a, input int dly, input logic [DW-1:0] d, input bit flush_mid);
    int idx;
    logic [9:0] tg;
    bit hit;
    idx = int'(a[5:0]);
    tg  = a[15:6];
    hit = mv[idx] && (mt[idx] == tg);
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    chk("req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (hit) begin
      mh++;
      chk("hit_rsp_valid", rsp_valid, 1'b1);
      chk("hit_rsp_data", rsp_data, md[idx]);
      chk("hit_no_memreq", mem_req, 1'b0);
    end else begin
      mm++;
      chk("miss_memreq", mem_req, 1'b1);
      chk("miss_memaddr", mem_addr, a);
      chk("miss_no_rsp", rsp_valid, 1'b0);
      for (int k = 0; k < dly; k++) begin
        if (flush_mid && k == 0) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fill_memreq_hold", mem_req, 1'b1);
        chk("fill_memaddr_hold", mem_addr, a);
      end
      mem_ack  = 1'b1;
      mem_data = d;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("fill_rsp_valid", rsp_valid, 1'b1);
      chk("fill_rsp_data", rsp_data, d);
      chk("fill_memreq_drop", mem_req, 1'b0);
      mv[idx] = 1'b1;
      mt[idx] = tg;
      md[idx] = d;
      if (flush_mid) begin
        wait_flush_done(0);
        return;
      end
    end
    @(posedge clk); #1;
    chk("rsp_pulse", rsp_valid, 1'b0);
  endtask

  task automatic do_flush();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
    #1;
    chk("flush_ready_low", req_ready, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("flush_req_ignored_mem", mem_req, 1'b0);
    chk("flush_req_ignored_rsp", rsp_valid, 1'b0);
    // flush stays high a few cycles into the walk; it must not restart it
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b0;
    wait_flush_done(3);
  endtask

  task automatic fill_stall(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int idx;
    idx = int'(a[5:0]);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mm++;
    chk("stall_memreq", mem_req, 1'b1);
    mem_ack  = 1'b1;
    mem_data = d;
    clk_en   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_no_rsp", rsp_valid, 1'b0);
      chk("stall_memreq_hold", mem_req, 1'b1);
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stall_rsp_valid", rsp_valid, 1'b1);
    chk("stall_rsp_data", rsp_data, d);
    mv[idx] = 1'b1;
    mt[idx] = a[15:6];
    md[idx] = d;
    @(posedge clk); #1;
    chk("stall_rsp_pulse", rsp_valid, 1'b0);
  endtask

  task automatic reset_mid_fill(input logic [AW-1:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_pre_memreq", mem_req, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_memreq_now", mem_req, 1'b0);
    chk("rst_memaddr_now", mem_addr, 16'h0000);
    chk("rst_rsp_valid_now", rsp_valid, 1'b0);
    model_clear();
    mh = 0;
    mm = 0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    mem_ack  = 1'b1;
    mem_data = 32'hBADC0DE0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("late_ack_no_rsp", rsp_valid, 1'b0);
      chk("late_ack_no_memreq", mem_req, 1'b0);
    end
    mem_ack = 1'b0;
`ifdef L1_ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 16'd0);
    chk("rst_miss_count", miss_count, 16'd0);
`endif
  endtask

  initial begin
    logic [AW-1:0] ha [4];
    rst_n = 1'b0; clk_en = 1'b1; req_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; req_addr = '0; mem_data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_addr", mem_addr, 16'h0);
    chk("reset_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fetch(16'h0005, 3, 32'hDEADBEEF, 1'b0);
    fetch(16'h0005, 0, 32'h0, 1'b0);
    fetch(16'h0045, 1, 32'h12345678, 1'b0);
    fetch(16'h0005, 2, 32'hCAFEF00D, 1'b0);
    fetch(16'h0045, 0, 32'h0, 1'b0);
    do_flush();
    fetch(16'h0045, 0, 32'h0BADF00D, 1'b0);
    fill_stall(16'h0077, 32'h5A5A1234);
    fetch(16'h0077, 0, 32'h0, 1'b0);

    // Back-to-back hits on freshly loaded lines.
    for (int i = 0; i < 4; i++) begin
      ha[i] = 16'h0100 + 16'(i);
      fetch(ha[i], 1, $urandom, 1'b0);
    end
    req_valid = 1'b1;
    req_addr  = ha[0];
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("streak_valid", rsp_valid, 1'b1);
      chk("streak_data", rsp_data, md[int'(ha[i % 4][5:0])]);
      mh++;
      req_addr = ha[(i + 1) % 4];
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("streak_end", rsp_valid, 1'b0);

    fetch(16'h0033, 2, 32'hF1F2F3F4, 1'b1);

    for (int it = 0; it < 150; it++) begin
      logic [AW-1:0] a;
      int dly;
      bit fm;
      a   = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      fm  = ($urandom_range(0, 14) == 0);
      dly = fm ? $urandom_range(1, 3) : $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) do_flush();
      fetch(a, dly, $urandom, fm);
    end

`ifdef L1_ICACHE_STATS_EN
    chk("stat_hits", hit_count, 16'(mh));
    chk("stat_misses", miss_count, 16'(mm));
`endif

    reset_mid_fill(16'h0009);
    fetch(16'h0009, 1, 32'h76543210, 1'b0);
    fetch(16'h0009, 0, 32'h0, 1'b0);
`ifdef L1_ICACHE_STATS_EN
    chk("post_rst_hits", hit_count, 16'(mh));
    chk("post_rst_misses", miss_count, 16'(mm));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
